// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM state encodings and AXI response codes for the CNN DMA slice
package cnn_pkg;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/cnn_dma_stream_ctrl.sv
// cnn_dma_stream_ctrl: AXI slave bridging W bursts to an output stream and an input stream to R bursts
module cnn_dma_stream_ctrl
  import cnn_pkg::*;
#(
  parameter int ID_W = 6,
  parameter int DATA_W = 512,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   awid,
  input  logic [LEN_W-1:0]  awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [LEN_W-1:0]  arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [31:0]       wr_bursts,
  output logic [31:0]       rd_bursts
);
  w_state_t          wstate;
  r_state_t          rstate;
  logic [ID_W-1:0]   wid_q, rid_q;
  logic [LEN_W-1:0]  wlen_q, rlen_q;
  logic [LEN_W:0]    wcnt, rcnt;
  logic [1:0]        bresp_q;
  logic              w_data, r_data, w_end;
  // Handshake outputs are gated by rst_n so nothing is offered while reset is held
  assign w_data   = rst_n && wstate == W_DATA;
  assign r_data   = rst_n && rstate == R_DATA;
  assign awready  = rst_n && wstate == W_IDLE;
  assign arready  = rst_n && rstate == R_IDLE;
  assign m_tdata  = wdata;
  assign m_tvalid = w_data & wvalid;
  assign wready   = w_data & m_tready;
  assign bvalid   = rst_n && wstate == W_RESP;
  assign bid      = wid_q;
  assign bresp    = bresp_q;
  assign w_end    = wcnt == {1'b0, wlen_q};
  assign rdata    = s_tdata;
  assign rvalid   = r_data & s_tvalid;
  assign s_tready = r_data & rready;
  assign rid      = rid_q;
  assign rresp    = OKAY;
  assign rlast    = r_data && rcnt == {1'b0, rlen_q};
  // Write FSM: accept AW, forward beats until length or early wlast, then hold B until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate    <= W_IDLE;
      wid_q     <= '0;
      wlen_q    <= '0;
      wcnt      <= '0;
      bresp_q   <= OKAY;
      wr_bursts <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (awvalid) begin
          wid_q  <= awid;
          wlen_q <= awlen;
          wcnt   <= '0;
          wstate <= W_DATA;
        end
        W_DATA: if (wvalid && wready) begin
          wcnt <= wcnt + 1'b1;
          if (w_end || wlast) begin
            bresp_q <= (w_end && wlast) ? OKAY : SLVERR;
            wstate  <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          wr_bursts <= wr_bursts + 1'b1;
          wstate    <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end
  // Read FSM: accept AR, pass stream beats to R, flag the final beat by count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate    <= R_IDLE;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt      <= '0;
      rd_bursts <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (arvalid) begin
          rid_q  <= arid;
          rlen_q <= arlen;
          rcnt   <= '0;
          rstate <= R_DATA;
        end
        R_DATA: if (rvalid && rready) begin
          if (rlast) begin
            rd_bursts <= rd_bursts + 1'b1;
            rstate    <= R_IDLE;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule
